// File: rtl/kitt_pkg.sv
// Shared types and constants for the KITT show sequencer: FSM states, scanner
// settings record, the show table and the shuffle LFSR constants.
package kitt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSED,
        ADVANCE
    } kitt_state_t;

    typedef struct packed {
        logic [1:0] mode;
        logic       speed;
        logic       oinv;
    } kitt_cfg_t;

    // Packed as {mode[1:0], speed, oinv}
    localparam kitt_cfg_t KITT_TABLE [0:7] = '{
        4'b0000, 4'b0010, 4'b0100, 4'b0110,
        4'b1000, 4'b1011, 4'b1100, 4'b1111
    };

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h5A;

    // One step of a right-shifting Galois LFSR
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/kitt_boundary_timer.sv
// Dwell and timeout counters: flags a sweep boundary (real or forced by timeout)
// and whether the current table entry has completed its dwell. Boundary is combinational.
module kitt_boundary_timer #(
    parameter int DWELL_SWEEPS = 4,
    parameter int TIMEOUT_CYC  = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    input  logic sweep_done,
    output logic boundary,
    output logic dwell_done
);

    localparam logic [7:0]  DWELL_N  = 8'(DWELL_SWEEPS);
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYC - 1);

    logic [7:0]  dwell_cnt;
    logic [23:0] tmo_cnt;

    assign boundary = cnt_en && (sweep_done || (tmo_cnt == TMO_LAST));

    // Level term covers a dwell that completed in the same cycle a pause began
    assign dwell_done = (dwell_cnt == DWELL_N) ||
                        (boundary && (dwell_cnt == DWELL_N - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            tmo_cnt   <= '0;
        end else if (clr) begin
            dwell_cnt <= '0;
            tmo_cnt   <= '0;
        end else if (cnt_en) begin
            if (boundary) begin
                if (dwell_cnt != DWELL_N)
                    dwell_cnt <= dwell_cnt + 8'd1;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 24'd1;
            end
        end
    end

endmodule

// File: rtl/kitt_show_sequencer.sv
// Show scheduler for kitt_scan_core: steps through KITT_TABLE at sweep boundaries,
// or passes manual pins through when auto_en=0. Define KITT_SHUFFLE_EN for LFSR order.
module kitt_show_sequencer
    import kitt_pkg::*;
#(
    parameter int DWELL_SWEEPS = 4,
    parameter int TIMEOUT_CYC  = 10_000_000,
    parameter int N_ENTRIES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auto_en,
    input  logic       pause,
    input  logic       skip,
    input  logic       man_ena,
    input  logic [1:0] man_mode,
    input  logic       man_speed,
    input  logic       man_oinv,
    input  logic       sweep_done,
    output logic       core_ena,
    output logic [1:0] core_mode,
    output logic       core_speed,
    output logic       core_oinv,
    output logic [2:0] step_idx,
    output logic       busy
);

    localparam logic [2:0] LAST_IDX = 3'(N_ENTRIES - 1);

    kitt_state_t state, state_nxt;
    kitt_cfg_t   cfg_q, cfg_nxt;
    logic        ena_q, ena_nxt;
    logic [2:0]  idx_q, idx_nxt;
    logic        busy_q, busy_nxt;
    logic        skip_pend, skip_pend_nxt;
    logic        boundary, dwell_done;
    logic [2:0]  seq_idx;

    kitt_boundary_timer #(
        .DWELL_SWEEPS (DWELL_SWEEPS),
        .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state == LOAD),
        .cnt_en     (state == RUN),
        .sweep_done (sweep_done),
        .boundary   (boundary),
        .dwell_done (dwell_done)
    );

    assign seq_idx = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;

`ifdef KITT_SHUFFLE_EN
    logic [7:0] lfsr, lfsr_nxt;
    logic [2:0] shuf_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= lfsr_nxt;
    end

    always_comb begin
        lfsr_nxt = lfsr;
        if (auto_en && state == ADVANCE)
            lfsr_nxt = lfsr_step(lfsr);
        shuf_idx = 3'(int'(lfsr_nxt[2:0]) % N_ENTRIES);
        if (shuf_idx == idx_q)
            shuf_idx = seq_idx;
    end
`else
    logic [2:0] shuf_idx;
    assign shuf_idx = seq_idx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cfg_q     <= '0;
            ena_q     <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            skip_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_q     <= cfg_nxt;
            ena_q     <= ena_nxt;
            idx_q     <= idx_nxt;
            busy_q    <= busy_nxt;
            skip_pend <= skip_pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cfg_nxt       = cfg_q;
        ena_nxt       = ena_q;
        idx_nxt       = idx_q;
        skip_pend_nxt = skip_pend;

        if ((state == RUN || state == PAUSED) && skip)
            skip_pend_nxt = 1'b1;

        case (state)
            IDLE: begin
                cfg_nxt = '{mode: man_mode, speed: man_speed, oinv: man_oinv};
                ena_nxt = man_ena;
                if (auto_en) begin
                    state_nxt = LOAD;
                    idx_nxt   = 3'd0;
                end
            end
            LOAD: begin
                cfg_nxt       = KITT_TABLE[idx_q];
                ena_nxt       = 1'b1;
                skip_pend_nxt = 1'b0;
                state_nxt     = RUN;
            end
            RUN: begin
                if (pause) begin
                    state_nxt = PAUSED;
                    ena_nxt   = 1'b0;
                end else if (dwell_done || (boundary && (skip_pend || skip))) begin
                    state_nxt = ADVANCE;
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_nxt = RUN;
                    ena_nxt   = 1'b1;
                end
            end
            ADVANCE: begin
                idx_nxt   = shuf_idx;
                state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase

        // Dropping auto_en wins over everything; index is kept for inspection
        if (!auto_en) begin
            state_nxt = IDLE;
            cfg_nxt   = '{mode: man_mode, speed: man_speed, oinv: man_oinv};
            ena_nxt   = man_ena;
            idx_nxt   = idx_q;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    assign core_ena   = ena_q;
    assign core_mode  = cfg_q.mode;
    assign core_speed = cfg_q.speed;
    assign core_oinv  = cfg_q.oinv;
    assign step_idx   = idx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_kitt_show_sequencer.sv
// Directed bench for kitt_show_sequencer with TIMEOUT_CYC shortened to 50.
module tb_kitt_show_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       auto_en = 1'b0;
    logic       pause = 1'b0;
    logic       skip = 1'b0;
    logic       man_ena = 1'b0;
    logic [1:0] man_mode = 2'd0;
    logic       man_speed = 1'b0;
    logic       man_oinv = 1'b0;
    logic       sweep_done = 1'b0;
    logic       core_ena;
    logic [1:0] core_mode;
    logic       core_speed;
    logic       core_oinv;
    logic [2:0] step_idx;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    kitt_show_sequencer #(
        .DWELL_SWEEPS (4),
        .TIMEOUT_CYC  (50),
        .N_ENTRIES    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .auto_en    (auto_en),
        .pause      (pause),
        .skip       (skip),
        .man_ena    (man_ena),
        .man_mode   (man_mode),
        .man_speed  (man_speed),
        .man_oinv   (man_oinv),
        .sweep_done (sweep_done),
        .core_ena   (core_ena),
        .core_mode  (core_mode),
        .core_speed (core_speed),
        .core_oinv  (core_oinv),
        .step_idx   (step_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns one negedge after the pulse was sampled
    task automatic sweep_pulse();
        sweep_done = 1'b1;
        @(negedge clk);
        sweep_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ena"},   32'(core_ena),   32'd0);
        chk({tag, "_mode"},  32'(core_mode),  32'd0);
        chk({tag, "_speed"}, 32'(core_speed), 32'd0);
        chk({tag, "_oinv"},  32'(core_oinv),  32'd0);
        chk({tag, "_idx"},   32'(step_idx),   32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
    endtask

    initial begin
        // Reset state
        tick(2);
        chk_all_zero("rst");

        // Manual pass-through, one cycle latency
        man_mode  = 2'd2;
        man_speed = 1'b1;
        man_oinv  = 1'b1;
        man_ena   = 1'b1;
        rst       = 1'b0;
        tick(1);
        chk("man_mode",  32'(core_mode),  32'd2);
        chk("man_speed", 32'(core_speed), 32'd1);
        chk("man_oinv",  32'(core_oinv),  32'd1);
        chk("man_ena",   32'(core_ena),   32'd1);
        chk("man_busy",  32'(busy),       32'd0);

        // Enter show: IDLE -> LOAD -> RUN with entry 0
        auto_en = 1'b1;
        tick(2);
        chk("load0_mode", 32'(core_mode), 32'd0);
        chk("load0_oinv", 32'(core_oinv), 32'd0);
        chk("load0_ena",  32'(core_ena),  32'd1);
        chk("load0_busy", 32'(busy),      32'd1);

        // Four sweeps complete the dwell of entry 0
        repeat (3) begin
            sweep_pulse();
            tick(3);
        end
        chk("dwell3_idx", 32'(step_idx), 32'd0);
        sweep_pulse();
        chk("adv_idx_e0", 32'(step_idx), 32'd0);
        tick(1);
        chk("adv_idx_e1", 32'(step_idx), 32'd1);
        tick(1);
        chk("e1_mode",  32'(core_mode),  32'd0);
        chk("e1_speed", 32'(core_speed), 32'd1);

        // Remaining 28 sweeps walk the table and wrap to 0
        for (int i = 0; i < 7; i++) begin
            repeat (4) begin
                sweep_pulse();
                tick(3);
            end
            chk("walk_idx", 32'(step_idx), 32'((i + 2) % 8));
            if (i == 3) begin
                chk("e5_mode", 32'(core_mode), 32'd2);
                chk("e5_oinv", 32'(core_oinv), 32'd1);
            end
        end
        chk("wrap_mode",  32'(core_mode),  32'd0);
        chk("wrap_speed", 32'(core_speed), 32'd0);

        // Skip after one sweep: acted on at the second sweep
        sweep_pulse();
        tick(3);
        skip = 1'b1;
        tick(1);
        skip = 1'b0;
        tick(2);
        chk("skip_wait_idx", 32'(step_idx), 32'd0);
        sweep_pulse();
        tick(1);
        chk("skip_adv_idx", 32'(step_idx), 32'd1);
        tick(2);

        // Pause freezes dwell count and drops core_ena
        sweep_pulse();
        tick(3);
        pause = 1'b1;
        tick(1);
        chk("pause_ena", 32'(core_ena), 32'd0);
        repeat (10) begin
            sweep_pulse();
            tick(9);
        end
        chk("paused_ena",  32'(core_ena), 32'd0);
        chk("paused_idx",  32'(step_idx), 32'd1);
        chk("paused_busy", 32'(busy),     32'd1);
        chk("paused_mode", 32'(core_mode), 32'd0);
        pause = 1'b0;
        tick(1);
        chk("resume_ena", 32'(core_ena), 32'd1);
        repeat (2) begin
            sweep_pulse();
            tick(3);
        end
        chk("resume_idx", 32'(step_idx), 32'd1);
        sweep_pulse();
        tick(1);
        chk("resume_adv_idx", 32'(step_idx), 32'd2);
        tick(1);

        // No sweeps: timeout forces a boundary every 50 cycles
        tick(190);
        chk("tmo_hold_idx", 32'(step_idx), 32'd2);
        tick(20);
        chk("tmo_adv_idx", 32'(step_idx), 32'd3);

        // Walk to entry 5, then reset mid-cycle
        repeat (8) begin
            sweep_pulse();
            tick(3);
        end
        chk("pre_rst_idx",  32'(step_idx),  32'd5);
        chk("pre_rst_mode", 32'(core_mode), 32'd2);
        chk("pre_rst_oinv", 32'(core_oinv), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");

        auto_en   = 1'b0;
        man_ena   = 1'b0;
        man_mode  = 2'd0;
        man_speed = 1'b0;
        man_oinv  = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(3);
        chk("post_rst_busy", 32'(busy),     32'd0);
        chk("post_rst_idx",  32'(step_idx), 32'd0);
        chk("post_rst_ena",  32'(core_ena), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
